// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the fetch unit and its helpers.
package rv32_pkg;

  localparam int XLEN = 32;

  // Opcodes that can change control flow
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational opcode classifier: flags words that may redirect control flow.
// Takes the whole word so the branch predictor can reuse it unchanged.
module fetch_predecode
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic            qualify,
  output logic            is_ctrl
);

  logic [6:0] opcode;
  logic       word_unused;

  assign opcode      = word[6:0];
  assign word_unused = ^word[XLEN-1:7];

  // Report jal/jalr/branch only when the caller says the word is live
  always_comb begin
    is_ctrl = 1'b0;
    if (qualify) begin
      case (opcode)
        OP_JAL, OP_JALR, OP_BRANCH: is_ctrl = 1'b1;
        default:                    is_ctrl = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues 1-cycle-latency word reads,
// pairs each returned word with its PC and handles pause, redirect and
// out-of-range halting.
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     MEM_WORDS   = 1024,
  parameter logic [XLEN-1:0] PRED_OFFSET = 32'd8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            l_pause,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_renable,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_addrpred,
  input  logic [XLEN-1:0] mem_rdata_pred,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            pred_is_ctrl,
  output logic            fetch_misalign,
  output logic            fetch_oob,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [XLEN-1:0] MEM_WORDS_W = XLEN'(MEM_WORDS);

  // A byte address is fetchable when its word index lies inside the memory
  function automatic logic in_range(input logic [XLEN-1:0] addr);
    return (addr >> 2) < MEM_WORDS_W;
  endfunction

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;
  logic            advance;
  logic            take_redirect;
  logic            consume;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign consume         = instr_valid && !l_pause && !redirect_valid;

  assign mem_addr     = pc_q;
  assign instr        = mem_rdata;
  assign mem_addrpred = instr_pc + PRED_OFFSET;

  // State register; reset forces the idle RESET state
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  // Next-state and control decode; redirect wins over pause outside RESET
  always_comb begin
    state_d       = state_q;
    mem_renable   = 1'b0;
    fetch_oob     = 1'b0;
    advance       = 1'b0;
    take_redirect = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = in_range(pc_q) ? ST_RUN : ST_HALT;
      end
      ST_RUN: begin
        mem_renable = 1'b1;
        if (redirect_valid) begin
          take_redirect = 1'b1;
          state_d       = in_range(redirect_target) ? ST_RUN : ST_HALT;
        end else if (!l_pause) begin
          advance = 1'b1;
          state_d = in_range(pc_plus4) ? ST_RUN : ST_HALT;
        end
      end
      ST_HALT: begin
        fetch_oob = 1'b1;
        if (redirect_valid) begin
          take_redirect = 1'b1;
          state_d       = in_range(redirect_target) ? ST_RUN : ST_HALT;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // PC, delivered-instruction tracking, misalignment flag and delivery count
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      fetch_misalign <= 1'b0;
      fetch_count    <= '0;
    end else begin
      if (consume) fetch_count <= fetch_count + 32'd1;
      if (take_redirect) begin
        pc_q           <= redirect_target;
        instr_valid    <= 1'b0;
        fetch_misalign <= (redirect_pc[1:0] != 2'b00);
      end else if (advance) begin
        pc_q        <= pc_plus4;
        instr_pc    <= pc_q;
        instr_valid <= 1'b1;
      end else if (state_q == ST_HALT && !l_pause) begin
        instr_valid <= 1'b0;
      end
    end
  end

  fetch_predecode u_predecode (
    .word    (mem_rdata_pred),
    .qualify (instr_valid),
    .is_ctrl (pred_is_ctrl)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a full-size instance and a 4-word instance
// share one stimulus stream and one instruction memory image; both are
// compared every cycle against a behavioural model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, l_pause, redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] a_mem_addr, a_mem_rdata, a_mem_addrpred, a_mem_rdata_pred;
  logic [31:0] a_instr, a_instr_pc, a_fetch_count;
  logic        a_mem_renable, a_instr_valid, a_pred_is_ctrl, a_fetch_misalign, a_fetch_oob;
  logic [31:0] b_mem_addr, b_mem_rdata, b_mem_addrpred, b_mem_rdata_pred;
  logic [31:0] b_instr, b_instr_pc, b_fetch_count;
  logic        b_mem_renable, b_instr_valid, b_pred_is_ctrl, b_fetch_misalign, b_fetch_oob;

  logic [31:0] mem [0:1023];

  int passed = 0;
  int total  = 0;
  bit checking = 1'b0;

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(1024), .PRED_OFFSET(32'd8)) dut_a (
    .clk(clk), .rst(rst), .l_pause(l_pause), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_addr(a_mem_addr), .mem_renable(a_mem_renable),
    .mem_rdata(a_mem_rdata), .mem_addrpred(a_mem_addrpred), .mem_rdata_pred(a_mem_rdata_pred),
    .instr_valid(a_instr_valid), .instr(a_instr), .instr_pc(a_instr_pc),
    .pred_is_ctrl(a_pred_is_ctrl), .fetch_misalign(a_fetch_misalign),
    .fetch_oob(a_fetch_oob), .fetch_count(a_fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4), .PRED_OFFSET(32'd8)) dut_b (
    .clk(clk), .rst(rst), .l_pause(l_pause), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_addr(b_mem_addr), .mem_renable(b_mem_renable),
    .mem_rdata(b_mem_rdata), .mem_addrpred(b_mem_addrpred), .mem_rdata_pred(b_mem_rdata_pred),
    .instr_valid(b_instr_valid), .instr(b_instr), .instr_pc(b_instr_pc),
    .pred_is_ctrl(b_pred_is_ctrl), .fetch_misalign(b_fetch_misalign),
    .fetch_oob(b_fetch_oob), .fetch_count(b_fetch_count)
  );

  // Instruction memories: registered read that holds while paused, plus a
  // combinational look-ahead port
  assign a_mem_rdata_pred = mem[a_mem_addrpred[11:2]];
  assign b_mem_rdata_pred = mem[b_mem_addrpred[11:2]];

  always @(posedge clk) begin
    if (!l_pause && a_mem_renable) a_mem_rdata <= mem[a_mem_addr[11:2]];
    if (!l_pause && b_mem_renable) b_mem_rdata <= mem[b_mem_addr[11:2]];
  end

  // Behavioural model: what the fetch unit must show after each clock edge
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;

  typedef struct {
    int          mode;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] cnt;
    bit          valid;
    bit          mis;
  } model_t;

  model_t ma, mb;

  function automatic bit fits(input logic [31:0] addr, input int words);
    return (addr / 4) < 32'(words);
  endfunction

  function automatic bit isCtrl(input logic [31:0] w);
    return (w[6:0] == 7'h6F) || (w[6:0] == 7'h67) || (w[6:0] == 7'h63);
  endfunction

  function automatic model_t step(input model_t m, input int words, input bit r,
                                  input bit p, input bit rv, input logic [31:0] rpc);
    model_t      n;
    logic [31:0] tgt;
    n = m;
    if (r) begin
      n.mode = M_IDLE; n.pc = 32'h0; n.ipc = 32'h0; n.cnt = 32'h0; n.valid = 0; n.mis = 0;
      return n;
    end
    if (m.valid && !p && !rv) n.cnt = m.cnt + 32'd1;
    if (m.mode == M_IDLE) begin
      n.mode = fits(m.pc, words) ? M_FETCH : M_HALT;
    end else if (rv) begin
      tgt     = rpc - (rpc % 4);
      n.pc    = tgt;
      n.valid = 0;
      n.mis   = (rpc % 4) != 0;
      n.mode  = fits(tgt, words) ? M_FETCH : M_HALT;
    end else if (!p) begin
      if (m.mode == M_FETCH) begin
        n.ipc   = m.pc;
        n.valid = 1;
        n.pc    = m.pc + 32'd4;
        n.mode  = fits(n.pc, words) ? M_FETCH : M_HALT;
      end else begin
        n.valid = 0;
      end
    end
    return n;
  endfunction

  // Advance both models on every rising edge with the inputs the DUTs saw
  always @(posedge clk) begin
    ma = step(ma, 1024, rst, l_pause, redirect_valid, redirect_pc);
    mb = step(mb, 4,    rst, l_pause, redirect_valid, redirect_pc);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic compareInst(input string tag, input model_t m,
                             input logic [31:0] addr, input logic ren, input logic [31:0] apred,
                             input logic valid, input logic [31:0] ins, input logic [31:0] ipc,
                             input logic pctrl, input logic mis, input logic oob,
                             input logic [31:0] cnt);
    logic [31:0] paddr;
    paddr = m.ipc + 32'd8;
    checkOutput({tag, ".mem_addr"},     addr,  m.pc);
    checkOutput({tag, ".mem_renable"},  32'(ren),   32'(m.mode == M_FETCH));
    checkOutput({tag, ".fetch_oob"},    32'(oob),   32'(m.mode == M_HALT));
    checkOutput({tag, ".instr_valid"},  32'(valid), 32'(m.valid));
    checkOutput({tag, ".instr_pc"},     ipc,   m.ipc);
    checkOutput({tag, ".mem_addrpred"}, apred, paddr);
    checkOutput({tag, ".pred_is_ctrl"}, 32'(pctrl), 32'(m.valid && isCtrl(mem[paddr[11:2]])));
    checkOutput({tag, ".fetch_misalign"}, 32'(mis), 32'(m.mis));
    checkOutput({tag, ".fetch_count"},  cnt,   m.cnt);
    if (m.valid) checkOutput({tag, ".instr"}, ins, mem[m.ipc[11:2]]);
  endtask

  // Per-cycle comparison of both DUTs against the model, away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      compareInst("A", ma, a_mem_addr, a_mem_renable, a_mem_addrpred, a_instr_valid, a_instr,
                  a_instr_pc, a_pred_is_ctrl, a_fetch_misalign, a_fetch_oob, a_fetch_count);
      compareInst("B", mb, b_mem_addr, b_mem_renable, b_mem_addrpred, b_instr_valid, b_instr,
                  b_instr_pc, b_pred_is_ctrl, b_fetch_misalign, b_fetch_oob, b_fetch_count);
    end
  end

  // Drive one cycle's inputs and return at the following falling edge
  task automatic applyStimulus(input bit r, input bit p, input bit rv, input logic [31:0] rpc);
    rst            = r;
    l_pause        = p;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin
    bit          r, p, rv;
    logic [31:0] rpc;

    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    mem[2]  = 32'h0000_006F;
    mem[20] = 32'h0000_0067;
    mem[21] = 32'h0000_0063;
    mem[22] = 32'h0000_00E3;
    mem[23] = 32'h0000_0013;

    rst = 1'b1; l_pause = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    checking = 1'b1;
    applyStimulus(1, 0, 0, 32'h0);

    // Reset state; look-ahead word is JAL but nothing is live yet
    checkOutput("lit.reset_valid",    32'(a_instr_valid), 32'd0);
    checkOutput("lit.reset_renable",  32'(a_mem_renable), 32'd0);
    checkOutput("lit.reset_count",    a_fetch_count, 32'd0);
    checkOutput("lit.reset_addrpred", a_mem_addrpred, 32'h8);
    checkOutput("lit.reset_predctrl", 32'(a_pred_is_ctrl), 32'd0);

    // Streaming from address 0
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.first_renable", 32'(a_mem_renable), 32'd1);
    checkOutput("lit.first_valid",   32'(a_instr_valid), 32'd0);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.w0_valid",    32'(a_instr_valid), 32'd1);
    checkOutput("lit.w0_instr",    a_instr, 32'h0);
    checkOutput("lit.w0_pc",       a_instr_pc, 32'h0);
    checkOutput("lit.w0_predctrl", 32'(a_pred_is_ctrl), 32'd1);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.w1_instr",    a_instr, 32'h1);
    checkOutput("lit.w1_pc",       a_instr_pc, 32'h4);
    checkOutput("lit.w1_predctrl", 32'(a_pred_is_ctrl), 32'd0);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.w2_instr", a_instr, 32'h6F);
    checkOutput("lit.w2_pc",    a_instr_pc, 32'h8);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.w3_instr", a_instr, 32'h3);
    checkOutput("lit.w3_pc",    a_instr_pc, 32'hC);
    checkOutput("lit.w3_count", a_fetch_count, 32'd3);
    checkOutput("lit.b_last_valid", 32'(b_instr_valid), 32'd1);
    checkOutput("lit.b_last_pc",    b_instr_pc, 32'hC);
    checkOutput("lit.b_oob",        32'(b_fetch_oob), 32'd1);
    checkOutput("lit.b_renable",    32'(b_mem_renable), 32'd0);

    // Pause for three cycles: everything frozen
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 32'h0);
      checkOutput("lit.pause_instr", a_instr, 32'h3);
      checkOutput("lit.pause_pc",    a_instr_pc, 32'hC);
      checkOutput("lit.pause_count", a_fetch_count, 32'd3);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.resume_pc",    a_instr_pc, 32'h10);
    checkOutput("lit.resume_instr", a_instr, 32'h4);
    checkOutput("lit.resume_count", a_fetch_count, 32'd4);
    checkOutput("lit.b_halt_valid", 32'(b_instr_valid), 32'd0);

    // Redirect to 0x40
    applyStimulus(0, 0, 1, 32'h40);
    checkOutput("lit.redir_valid", 32'(a_instr_valid), 32'd0);
    checkOutput("lit.redir_addr",  a_mem_addr, 32'h40);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.redir_pc",    a_instr_pc, 32'h40);
    checkOutput("lit.redir_instr", a_instr, 32'd16);

    // Redirect under pause to a misaligned target
    applyStimulus(0, 1, 1, 32'h22);
    checkOutput("lit.mis_addr",  a_mem_addr, 32'h20);
    checkOutput("lit.mis_flag",  32'(a_fetch_misalign), 32'd1);
    checkOutput("lit.mis_valid", 32'(a_instr_valid), 32'd0);
    applyStimulus(0, 1, 0, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("lit.mis_held_valid", 32'(a_instr_valid), 32'd0);
    checkOutput("lit.mis_held_addr",  a_mem_addr, 32'h20);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.mis_resume_valid", 32'(a_instr_valid), 32'd1);
    checkOutput("lit.mis_resume_pc",    a_instr_pc, 32'h20);
    checkOutput("lit.mis_resume_instr", a_instr, 32'h8);

    // Redirect to 0 brings the small instance back out of HALT
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("lit.b_exit_oob",     32'(b_fetch_oob), 32'd0);
    checkOutput("lit.b_exit_renable", 32'(b_mem_renable), 32'd1);
    checkOutput("lit.b_exit_mis",     32'(b_fetch_misalign), 32'd0);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("lit.jal_predctrl", 32'(a_pred_is_ctrl), 32'd1);

    // Randomised traffic: pauses, redirects (in range, near the top, misaligned), resets
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 299) == 0);
      p  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 32'($urandom_range(4076, 4100));
        1:       rpc = 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      applyStimulus(r, p, rv, rpc);
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
